// File: rtl/voice_pkg.sv
// Shared constants, sequencer state encoding and the note-to-phase-increment
// table used by the voice allocator and the scheduler.
package voice_pkg;

   localparam int PHASE_W  = 13;
   localparam int SAMPLE_W = 16;
   localparam int SCALE_W  = 8;
   localparam logic [3:0] MAX_NOTE = 4'd12;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_ACC,
      S_OUT
   } state_t;

   function automatic logic [SCALE_W-1:0] note_scale(input logic [3:0] note);
      case (note)
         4'd0:    return 8'd74;
         4'd1:    return 8'd78;
         4'd2:    return 8'd83;
         4'd3:    return 8'd88;
         4'd4:    return 8'd93;
         4'd5:    return 8'd99;
         4'd6:    return 8'd104;
         4'd7:    return 8'd111;
         4'd8:    return 8'd117;
         4'd9:    return 8'd124;
         4'd10:   return 8'd132;
         4'd11:   return 8'd139;
         4'd12:   return 8'd148;
         default: return 8'd0;
      endcase
   endfunction

endpackage

// File: rtl/voice_alloc.sv
// Voice allocation table: key events allocate, retrigger, steal or free voices.
// phase_clear tells the scheduler which voice phase restarts at the next edge.
module voice_alloc
   import voice_pkg::*;
#(
   parameter int NUM_VOICES = 4
) (
   input  logic                          clk_50,
   input  logic                          ar,
   input  logic                          key_evt,
   input  logic                          key_on,
   input  logic [3:0]                    key_val,
   output logic [NUM_VOICES-1:0]         alloc,
   output logic [NUM_VOICES*SCALE_W-1:0] scale_vec,
   output logic [NUM_VOICES-1:0]         phase_clear
);

   localparam int VW = $clog2(NUM_VOICES);

   logic [NUM_VOICES-1:0] alloc_reg;
   logic [3:0]            key_reg   [NUM_VOICES];
   logic [SCALE_W-1:0]    scale_reg [NUM_VOICES];
   logic [VW-1:0]         steal_reg;

   logic [NUM_VOICES-1:0] hit;
   logic [NUM_VOICES-1:0] press_sel;
   logic [NUM_VOICES-1:0] release_sel;
   logic [VW-1:0]         free_idx;
   logic                  ev_ok;
   logic                  full;

   assign ev_ok = key_evt && (key_val <= MAX_NOTE);
   assign full  = &alloc_reg;

   for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      assign hit[gi] = alloc_reg[gi] && (key_reg[gi] == key_val);
      assign scale_vec[gi*SCALE_W +: SCALE_W] = scale_reg[gi];
   end

   // Descending scan so the lowest free index wins.
   always_comb begin
      free_idx = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (!alloc_reg[i]) free_idx = VW'(i);
      end
   end

   always_comb begin
      press_sel = '0;
      if (|hit)       press_sel = hit;
      else if (!full) press_sel[free_idx] = 1'b1;
      else            press_sel[steal_reg] = 1'b1;
   end

   assign phase_clear = (ev_ok && key_on)  ? press_sel : '0;
   assign release_sel = (ev_ok && !key_on) ? hit       : '0;

   always_ff @(posedge clk_50 or negedge ar) begin
      if (!ar) begin
         alloc_reg <= '0;
         steal_reg <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            key_reg[i]   <= '0;
            scale_reg[i] <= '0;
         end
      end else begin
         if (ev_ok && key_on && !(|hit) && full) steal_reg <= steal_reg + VW'(1);
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (phase_clear[i]) begin
               alloc_reg[i] <= 1'b1;
               key_reg[i]   <= key_val;
               scale_reg[i] <= note_scale(key_val);
            end else if (release_sel[i]) begin
               alloc_reg[i] <= 1'b0;
               scale_reg[i] <= '0;
            end
         end
      end
   end

   assign alloc = alloc_reg;

endmodule

// File: rtl/voice_scheduler.sv
// Polyphonic voice scheduler: one shared wavetable read per active voice per tick, mixed.
// Optional SATURATE_MIX_EN: output the saturated raw sum instead of the shifted average.
module voice_scheduler
   import voice_pkg::*;
#(
   parameter int NUM_VOICES  = 4,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic                  clk_50,
   input  logic                  ar,
   input  logic                  sample_tick,
   input  logic                  key_evt,
   input  logic                  key_on,
   input  logic [3:0]            key_val,
   input  logic [1:0]            wave_select,
   output logic [14:0]           mem_addr,
   output logic                  mem_rd,
   input  logic [15:0]           mem_dout,
   input  logic                  mem_done,
   output logic [15:0]           mix_out,
   output logic                  mix_valid,
   output logic [NUM_VOICES-1:0] active_voices,
   output logic                  overrun
);

   localparam int VW    = $clog2(NUM_VOICES);
   localparam int ACC_W = SAMPLE_W + VW;
   localparam int TW    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [VW-1:0] LAST_V   = VW'(NUM_VOICES - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

   state_t                      state_reg;
   logic [VW-1:0]               v_reg;
   logic signed [ACC_W-1:0]     acc_reg;
   logic signed [SAMPLE_W-1:0]  sample_reg;
   logic [TW-1:0]               tmo_reg;
   logic [1:0]                  wsel_reg;
   logic [PHASE_W-1:0]          phase_reg [NUM_VOICES];
   logic [SCALE_W-1:0]          scale     [NUM_VOICES];
   logic [NUM_VOICES-1:0]       alloc;
   logic [NUM_VOICES-1:0]       phase_clear;
   logic [NUM_VOICES*SCALE_W-1:0] scale_vec;
   logic signed [SAMPLE_W-1:0]  mix_next;

   voice_alloc #(
      .NUM_VOICES(NUM_VOICES)
   ) u_alloc (
      .clk_50     (clk_50),
      .ar         (ar),
      .key_evt    (key_evt),
      .key_on     (key_on),
      .key_val    (key_val),
      .alloc      (alloc),
      .scale_vec  (scale_vec),
      .phase_clear(phase_clear)
   );

   assign active_voices = alloc;

   for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_scale
      assign scale[gi] = scale_vec[gi*SCALE_W +: SCALE_W];
   end

`ifdef SATURATE_MIX_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(SAMPLE_W-1) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   always_comb begin
      if (acc_reg > SAT_MAX)      mix_next = 16'sh7fff;
      else if (acc_reg < SAT_MIN) mix_next = 16'sh8000;
      else                        mix_next = acc_reg[SAMPLE_W-1:0];
   end
`else
   assign mix_next = SAMPLE_W'(acc_reg >>> VW);
`endif

   // A retrigger on the same edge as the accumulate step wins.
   always_ff @(posedge clk_50 or negedge ar) begin
      if (!ar) begin
         for (int i = 0; i < NUM_VOICES; i++) phase_reg[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (phase_clear[i])
               phase_reg[i] <= '0;
            else if (state_reg == S_ACC && v_reg == VW'(i))
               phase_reg[i] <= phase_reg[i] + PHASE_W'(scale[i]);
         end
      end
   end

   always_ff @(posedge clk_50 or negedge ar) begin
      if (!ar) begin
         state_reg  <= S_IDLE;
         v_reg      <= '0;
         acc_reg    <= '0;
         sample_reg <= '0;
         tmo_reg    <= '0;
         wsel_reg   <= '0;
         mem_addr   <= '0;
         mem_rd     <= 1'b0;
         mix_out    <= '0;
         mix_valid  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         mix_valid <= 1'b0;
         if (sample_tick && state_reg != S_IDLE) overrun <= 1'b1;
         case (state_reg)
            S_IDLE: begin
               if (sample_tick) begin
                  wsel_reg  <= wave_select;
                  acc_reg   <= '0;
                  v_reg     <= '0;
                  state_reg <= (|alloc) ? S_ISSUE : S_OUT;
               end
            end
            S_ISSUE: begin
               if (alloc[v_reg]) begin
                  mem_addr  <= {wsel_reg, phase_reg[v_reg]};
                  mem_rd    <= 1'b1;
                  tmo_reg   <= '0;
                  state_reg <= S_WAIT;
               end else if (v_reg == LAST_V) begin
                  state_reg <= S_OUT;
               end else begin
                  v_reg <= v_reg + VW'(1);
               end
            end
            S_WAIT: begin
               tmo_reg <= tmo_reg + TW'(1);
               if (mem_done) begin
                  sample_reg <= mem_dout;
                  mem_rd     <= 1'b0;
                  state_reg  <= S_ACC;
               end else if (tmo_reg == TMO_LAST) begin
                  sample_reg <= '0;
                  mem_rd     <= 1'b0;
                  state_reg  <= S_ACC;
               end
            end
            S_ACC: begin
               acc_reg <= acc_reg + ACC_W'(sample_reg);
               if (v_reg == LAST_V) begin
                  state_reg <= S_OUT;
               end else begin
                  v_reg     <= v_reg + VW'(1);
                  state_reg <= S_ISSUE;
               end
            end
            S_OUT: begin
               mix_out   <= mix_next;
               mix_valid <= 1'b1;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: a small memory responder, a mix_valid
// monitor and a linear sequence of key/tick steps with hand-computed results.
module tb_voice_scheduler;

`ifdef SATURATE_MIX_EN
   localparam logic [15:0] MIX1 = 16'h1000;
   localparam logic [15:0] MIX3 = 16'h3000;
   localparam logic [15:0] MIX4 = 16'h4000;
`else
   localparam logic [15:0] MIX1 = 16'h0400;
   localparam logic [15:0] MIX3 = 16'h0C00;
   localparam logic [15:0] MIX4 = 16'h1000;
`endif

   logic        clk_50;
   logic        ar;
   logic        sample_tick;
   logic        key_evt;
   logic        key_on;
   logic [3:0]  key_val;
   logic [1:0]  wave_select;
   logic [14:0] mem_addr;
   logic        mem_rd;
   logic [15:0] mem_dout;
   logic        mem_done;
   logic [15:0] mix_out;
   logic        mix_valid;
   logic [3:0]  active_voices;
   logic        overrun;

   int total = 0;
   int bad = 0;
   int mv_count = 0;
   int mv_start = 0;
   int rd_pulses = 0;
   int rd_cnt = 0;
   int last_rd_len = 0;
   int resp_delay = 2;
   logic withhold = 1'b0;
   logic [15:0] resp_data = 16'h1000;
   logic [15:0] last_mix = 16'h0000;
   logic [14:0] addr_log[$];

   voice_scheduler #(
      .NUM_VOICES (4),
      .MEM_TIMEOUT(64)
   ) dut (
      .clk_50       (clk_50),
      .ar           (ar),
      .sample_tick  (sample_tick),
      .key_evt      (key_evt),
      .key_on       (key_on),
      .key_val      (key_val),
      .wave_select  (wave_select),
      .mem_addr     (mem_addr),
      .mem_rd       (mem_rd),
      .mem_dout     (mem_dout),
      .mem_done     (mem_done),
      .mix_out      (mix_out),
      .mix_valid    (mix_valid),
      .active_voices(active_voices),
      .overrun      (overrun)
   );

   initial begin
      clk_50 = 1'b0;
      forever #5 clk_50 = ~clk_50;
   end

   // Memory responder: pulses mem_done resp_delay cycles after mem_rd rises.
   initial begin
      mem_done = 1'b0;
      mem_dout = 16'h0000;
      forever begin
         @(posedge clk_50);
         #1;
         mem_done = 1'b0;
         if (mem_rd === 1'b1) begin
            if (rd_cnt == 0) begin
               rd_pulses++;
               addr_log.push_back(mem_addr);
            end
            rd_cnt++;
            if (!withhold && rd_cnt == resp_delay) begin
               mem_done = 1'b1;
               mem_dout = resp_data;
            end
         end else begin
            if (rd_cnt != 0) last_rd_len = rd_cnt;
            rd_cnt = 0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk_50);
         #1;
         if (mix_valid === 1'b1) begin
            mv_count++;
            last_mix = mix_out;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic key(input logic on, input logic [3:0] val);
      @(negedge clk_50);
      key_evt = 1'b1;
      key_on  = on;
      key_val = val;
      @(negedge clk_50);
      key_evt = 1'b0;
   endtask

   task automatic tick_start(input logic [1:0] ws);
      @(negedge clk_50);
      mv_start  = mv_count;
      rd_pulses = 0;
      addr_log.delete();
      wave_select = ws;
      sample_tick = 1'b1;
      @(negedge clk_50);
      sample_tick = 1'b0;
   endtask

   task automatic tick_finish(input string tag, input int exp_reads, input logic [15:0] exp_mix);
      for (int i = 0; i < 400 && mv_count == mv_start; i++) @(posedge clk_50);
      repeat (3) @(posedge clk_50);
      #2;
      chk({tag, "_valid"}, mv_count - mv_start, 1);
      chk({tag, "_reads"}, rd_pulses, exp_reads);
      chk({tag, "_mix"}, last_mix, exp_mix);
      $display("tick %s: mix_out=%h reads=%0d", tag, last_mix, rd_pulses);
   endtask

   task automatic wait_read(input string tag, input int n);
      int i;
      i = 0;
      while (i < 300 && !(mem_rd === 1'b1 && addr_log.size() == n)) begin
         @(posedge clk_50);
         #2;
         i++;
      end
      chk(tag, {31'd0, mem_rd}, 1);
   endtask

   initial begin
      ar = 1'b0;
      sample_tick = 1'b0;
      key_evt = 1'b0;
      key_on = 1'b0;
      key_val = 4'd0;
      wave_select = 2'b00;
      repeat (3) @(posedge clk_50);
      #1;
      chk("rst_mix_out", mix_out, 0);
      chk("rst_mix_valid", mix_valid, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_active", active_voices, 0);
      chk("rst_overrun", overrun, 0);
      @(negedge clk_50);
      ar = 1'b1;

      tick_start(2'b00);
      tick_finish("empty", 0, 16'h0000);

      key(1'b1, 4'd0);
      chk("alloc_key0", active_voices, 4'b0001);
      tick_start(2'b00);
      tick_finish("k0_t1", 1, MIX1);
      chk("k0_t1_addr", addr_log[0], 15'd0);
      tick_start(2'b00);
      tick_finish("k0_t2", 1, MIX1);
      chk("k0_t2_addr", addr_log[0], 15'd74);
      tick_start(2'b01);
      tick_finish("k0_t3", 1, MIX1);
      chk("k0_t3_addr", addr_log[0], {2'b01, 13'd148});

      key(1'b0, 4'd0);
      chk("release_key0", active_voices, 4'b0000);
      key(1'b1, 4'd3);
      key(1'b1, 4'd5);
      key(1'b1, 4'd7);
      key(1'b1, 4'd12);
      chk("four_keys", active_voices, 4'b1111);
      key(1'b1, 4'd9);
      chk("steal_v0", active_voices, 4'b1111);
      tick_start(2'b00);
      tick_finish("full4", 4, MIX4);

      tick_start(2'b00);
      wait_read("wait_v1", 2);
      key(1'b0, 4'd5);
      tick_finish("rel_in_wait", 4, MIX4);
      chk("rel_addr_v0", addr_log[0], 15'd124);
      chk("rel_addr_v1", addr_log[1], 15'd99);
      chk("rel_addr_v2", addr_log[2], 15'd111);
      chk("rel_addr_v3", addr_log[3], 15'd148);
      chk("rel_active", active_voices, 4'b1101);

      tick_start(2'b00);
      tick_finish("skip_v1", 3, MIX3);
      chk("skip_addr_v0", addr_log[0], 15'd248);
      chk("skip_addr_v2", addr_log[1], 15'd222);
      chk("skip_addr_v3", addr_log[2], 15'd296);

      key(1'b1, 4'd2);
      chk("refill_v1", active_voices, 4'b1111);
      key(1'b1, 4'd4);
      chk("steal_v1", active_voices, 4'b1111);
      key(1'b0, 4'd2);
      chk("release_not_held", active_voices, 4'b1111);
      key(1'b0, 4'd4);
      chk("release_stolen", active_voices, 4'b1101);
      key(1'b1, 4'd13);
      chk("ignore_key13", active_voices, 4'b1101);

      withhold = 1'b1;
      tick_start(2'b00);
      tick_finish("timeout", 3, 16'h0000);
      chk("timeout_len", last_rd_len, 64);
      withhold = 1'b0;
      chk("no_overrun_yet", overrun, 0);

      tick_start(2'b00);
      wait_read("ovr_wait", 1);
      @(negedge clk_50);
      sample_tick = 1'b1;
      @(negedge clk_50);
      sample_tick = 1'b0;
      chk("overrun_set", overrun, 1);
      tick_finish("overrun", 3, MIX3);
      repeat (20) @(posedge clk_50);
      #2;
      chk("overrun_one_mix", mv_count - mv_start, 1);
      chk("overrun_sticky", overrun, 1);

      tick_start(2'b00);
      wait_read("rst_wait", 1);
      ar = 1'b0;
      #1;
      chk("rst_mid_mem_rd", mem_rd, 0);
      chk("rst_mid_active", active_voices, 0);
      chk("rst_mid_overrun", overrun, 0);
      @(negedge clk_50);
      ar = 1'b1;
      repeat (20) @(posedge clk_50);
      #2;
      chk("rst_mid_no_mix", mv_count - mv_start, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
